rle_encoder_stream: RTL
=======================

// Module: rle_encoder_stream
// PURPOSE
//  Parametrised run-length encoder with valid/ready streaming on both sides.
//  It compresses activation/weight bytes from the CNN datapath into
//  (value, length) tokens before they are stored in, or sent across, the
//  SoC interconnect.
//  Additions over the fixed 8-bit encoder:
//   - configurable value and length widths
//   - backpressure
//   - end-of-stream flush via in_last
//   - run-length saturation
//   - zero-only run mode for sparse feature maps
// PARAMETERS
//  DATA_W     8   width of input symbol / out_value
//  LEN_W      8   width of out_length; MAX_LEN = 2**LEN_W-1
//  ZERO_ONLY  0   0: all equal symbols merge; 1: only value 0 merges, nonzero always len 1
// PORTS
//  clk         in   1       single clock, rising edge
//  rst_n       in   1       asynchronous, active-low reset
//  in_data     in   DATA_W  input symbol
//  in_valid    in   1       in_data valid
//  in_last     in   1       qualifies the final symbol of a stream
//  in_ready    out  1       encoder accepts a symbol this cycle
//  out_value   out  DATA_W  run symbol
//  out_length  out  LEN_W   run length, 1..MAX_LEN (never 0)
//  out_last    out  1       token is the final run of the stream
//  out_valid   out  1       token valid
//  out_ready   in   1       downstream accepts token
//  run_count   out  16      tokens emitted since reset; wraps at 2**16
// BEHAVIOUR
//  Reset values: out_valid=0, out_last=0, out_value=0, out_length=0, run_count=0.
//   Reset drops any partial run; state goes to IDLE.
//  Handshakes: input accepted when in_valid&in_ready; token transferred when
//   out_valid&out_ready. out_* are registered and held stable while out_valid&!out_ready.
//  in_ready = (state!=FLUSH) & (!out_valid | out_ready). Combinational, no in_valid dependence.
//  FSM states:
//   IDLE  - no open run
//   RUN   - open run: cur_val, cur_len
//   FLUSH - one extra token pending after a last-with-mismatch
//  "match" = in_data==cur_val & cur_len<MAX_LEN & (!ZERO_ONLY | in_data==0).
//  On an accepted beat:
//   IDLE, !last        -> RUN, cur_val=in_data, cur_len=1; no token.
//   IDLE, last         -> token (in_data,1,last=1); stay IDLE.
//   RUN, match, !last  -> cur_len+1; no token.
//   RUN, match, last   -> token (cur_val,cur_len+1,last=1); -> IDLE.
//   RUN, !match, !last -> token (cur_val,cur_len,last=0); new run (in_data,1); stay RUN.
//   RUN, !match, last  -> token (cur_val,cur_len,0); hold (in_data,1); -> FLUSH.
//   FLUSH              -> when output slot free, token (held,1,last=1); -> IDLE.
//  Saturation: a run reaching MAX_LEN is emitted on the next mismatching or
//   over-length beat. Example, LEN_W=8: 256 equal symbols -> (v,255),(v,1).
//  Latency: a token appears the cycle after the accepting beat that closes it.
//  No idle timeout: an open run persists indefinitely without in_last.
//  run_count increments on each output transfer.
//  Simultaneous transfer: when the output drains and a new token loads in the
//   same cycle, out_valid stays 1 and there is no bubble.
//  Invariant: no symbol is lost or duplicated. The sum of out_length equals
//   the number of accepted beats, per stream.
// STRUCTURE
//  Shared package cnn_acc_pkg:
//   - rle_state_e {IDLE,RUN,FLUSH}
//   - RLE_DATA_W_DEF and RLE_LEN_W_DEF constants
//  Sub-module: rle_out_reg, a one-entry valid/ready output register
//   (value, length, last).
//  Run tracking and FSM sit in this module.
// TESTING
//  1. A,A,A,B,B,A(last), no backpressure -> (65,3,0),(66,2,0),(65,1,1); run_count=3.
//  2. 300 x 0x00 then last, LEN_W=8 -> (0,255,0),(0,45,1).
//  3. ZERO_ONLY=1: 0,0,7,7,0(last) -> (0,2,0),(7,1,0),(7,1,0),(0,1,1).
//  4. out_ready=0 for 5 cycles mid-stream -> in_ready=0; out_* stable; no token lost.
//  5. Single symbol 9 with last -> (9,1,1) next cycle; A,B(last) -> FLUSH path, (A,1,0),(B,1,1).
//  6. rst_n low while in RUN with cur_len=4 -> out_valid=0 immediately; next stream unaffected.

Source files
------------

// File: rtl/cnn_acc_pkg.sv
// Shared types and defaults for the CNN accelerator stream blocks.
// Holds the run-length encoder state encoding and width defaults.
package cnn_acc_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } rle_state_e;

  localparam int unsigned RLE_DATA_W_DEF = 8;
  localparam int unsigned RLE_LEN_W_DEF  = 8;

endpackage

// File: rtl/rle_out_reg.sv
// One-entry valid/ready output register for RLE tokens.
// A load wins over a drain in the same cycle, so back-to-back tokens have no bubble.
module rle_out_reg #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned LEN_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ld_i,
  input  logic [DATA_W-1:0] value_i,
  input  logic [LEN_W-1:0]  length_i,
  input  logic              last_i,
  input  logic              ready_i,
  output logic              valid_o,
  output logic [DATA_W-1:0] value_o,
  output logic [LEN_W-1:0]  length_o,
  output logic              last_o
);

  logic              valid_q;
  logic [DATA_W-1:0] value_q;
  logic [LEN_W-1:0]  length_q;
  logic              last_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q  <= 1'b0;
      value_q  <= '0;
      length_q <= '0;
      last_q   <= 1'b0;
    end else if (ld_i) begin
      valid_q  <= 1'b1;
      value_q  <= value_i;
      length_q <= length_i;
      last_q   <= last_i;
    end else if (valid_q && ready_i) begin
      valid_q  <= 1'b0;
    end
  end

  assign valid_o  = valid_q;
  assign value_o  = value_q;
  assign length_o = length_q;
  assign last_o   = last_q;

endmodule

// File: rtl/rle_encoder_stream.sv
// Streaming run-length encoder: valid/ready in, (value,length,last) tokens out.
// Supports length saturation, in_last flush and a zero-only merge mode.
module rle_encoder_stream
  import cnn_acc_pkg::*;
#(
  parameter int unsigned DATA_W    = RLE_DATA_W_DEF,
  parameter int unsigned LEN_W     = RLE_LEN_W_DEF,
  parameter bit          ZERO_ONLY = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  input  logic              in_last,
  output logic              in_ready,
  output logic [DATA_W-1:0] out_value,
  output logic [LEN_W-1:0]  out_length,
  output logic              out_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [15:0]       run_count
);

  localparam logic [LEN_W-1:0] MAX_LEN = '1;
  localparam logic [LEN_W-1:0] ONE     = LEN_W'(1);

  rle_state_e        state_q, state_d;
  logic [DATA_W-1:0] val_q, val_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [15:0]       cnt_q;

  logic              slot_free;
  logic              accept;
  logic              match;
  logic              ld;
  logic [DATA_W-1:0] tok_val;
  logic [LEN_W-1:0]  tok_len;
  logic              tok_last;

  assign slot_free = !out_valid || out_ready;
  assign in_ready  = (state_q != FLUSH) && slot_free;
  assign accept    = in_valid && in_ready;
  assign match     = (in_data == val_q) && (len_q < MAX_LEN) &&
                     (!ZERO_ONLY || (in_data == '0));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      val_q   <= '0;
      len_q   <= '0;
    end else begin
      state_q <= state_d;
      val_q   <= val_d;
      len_q   <= len_d;
    end
  end

  always_comb begin
    state_d = state_q;
    val_d   = val_q;
    len_d   = len_q;
    unique case (state_q)
      IDLE: begin
        if (accept && !in_last) begin
          state_d = RUN;
          val_d   = in_data;
          len_d   = ONE;
        end
      end
      RUN: begin
        if (accept) begin
          if (match && !in_last) begin
            len_d = len_q + ONE;
          end else if (match) begin
            state_d = IDLE;
          end else begin
            // The mismatching symbol opens the next run, or waits in FLUSH
            state_d = in_last ? FLUSH : RUN;
            val_d   = in_data;
            len_d   = ONE;
          end
        end
      end
      FLUSH: begin
        if (slot_free) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ld       = 1'b0;
    tok_val  = val_q;
    tok_len  = len_q;
    tok_last = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (accept && in_last) begin
          ld       = 1'b1;
          tok_val  = in_data;
          tok_len  = ONE;
          tok_last = 1'b1;
        end
      end
      RUN: begin
        if (accept && match && in_last) begin
          ld       = 1'b1;
          tok_len  = len_q + ONE;
          tok_last = 1'b1;
        end else if (accept && !match) begin
          ld       = 1'b1;
        end
      end
      FLUSH: begin
        if (slot_free) begin
          ld       = 1'b1;
          tok_len  = ONE;
          tok_last = 1'b1;
        end
      end
      default: ld = 1'b0;
    endcase
  end

  rle_out_reg #(
    .DATA_W (DATA_W),
    .LEN_W  (LEN_W)
  ) u_out (
    .clk      (clk),
    .rst_n    (rst_n),
    .ld_i     (ld),
    .value_i  (tok_val),
    .length_i (tok_len),
    .last_i   (tok_last),
    .ready_i  (out_ready),
    .valid_o  (out_valid),
    .value_o  (out_value),
    .length_o (out_length),
    .last_o   (out_last)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (out_valid && out_ready) begin
      cnt_q <= cnt_q + 16'd1;
    end
  end

  assign run_count = cnt_q;

endmodule
